// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - op-code and FSM state definitions shared by the ALU/mul-div unit
package alu_defs;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_RSVD  = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return op[3:1] == 3'b110;
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op[3:1] == 3'b111;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - radix-2 shift-add multiplier / restoring divider on magnitudes
// The first iteration happens on the start edge, the last one feeds o_lo/o_hi while o_done is high.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);
  localparam int SHW = $clog2(WIDTH);

  logic             r_busy, r_is_div, r_neg_q, r_neg_r;
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_m;

  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_src_acc, w_src_q, w_src_m;
  logic               w_src_div, w_borrow;
  logic [WIDTH:0]     w_msum, w_shift;
  logic [WIDTH-1:0]   w_acc_nx, w_q_nx, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod, w_pfix;

  assign w_mag_a = (i_is_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign w_mag_b = (i_is_signed && i_b[WIDTH-1]) ? -i_b : i_b;

  assign w_src_div = i_start ? i_is_div : r_is_div;
  assign w_src_acc = i_start ? '0 : r_acc;
  assign w_src_q   = i_start ? (i_is_div ? w_mag_a : w_mag_b) : r_q;
  assign w_src_m   = i_start ? (i_is_div ? w_mag_b : w_mag_a) : r_m;

  assign w_msum   = {1'b0, w_src_acc} + (w_src_q[0] ? {1'b0, w_src_m} : '0);
  assign w_shift  = {w_src_acc, w_src_q[WIDTH-1]};
  assign w_borrow = w_shift < {1'b0, w_src_m};

  always_comb begin
    w_acc_nx = w_msum[WIDTH:1];
    w_q_nx   = {w_msum[0], w_src_q[WIDTH-1:1]};
    if (w_src_div) begin
      w_acc_nx = w_borrow ? w_shift[WIDTH-1:0] : w_shift[WIDTH-1:0] - w_src_m;
      w_q_nx   = {w_src_q[WIDTH-2:0], ~w_borrow};
    end
  end

  assign w_prod = {w_acc_nx, w_q_nx};
  assign w_pfix = r_neg_q ? -w_prod : w_prod;
  assign w_quo  = r_neg_q ? -w_q_nx : w_q_nx;
  assign w_rem  = r_neg_r ? -w_acc_nx : w_acc_nx;

  assign o_lo   = r_is_div ? w_quo : w_pfix[WIDTH-1:0];
  assign o_hi   = r_is_div ? w_rem : w_pfix[2*WIDTH-1:WIDTH];
  assign o_done = r_busy && (r_cnt == SHW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_is_div <= i_is_div;
      r_neg_q  <= i_is_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
      r_neg_r  <= i_is_div && i_is_signed && i_a[WIDTH-1];
      r_cnt    <= SHW'(1);
      r_acc    <= w_acc_nx;
      r_q      <= w_q_nx;
      r_m      <= w_src_m;
    end else if (r_busy) begin
      if (o_done) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt + SHW'(1);
        r_acc <= w_acc_nx;
        r_q   <= w_q_nx;
      end
    end
  end

endmodule

// File: rtl/pipelined_alu_muldiv.sv
// rtl/pipelined_alu_muldiv.sv - EX-stage ALU with iterative mul/div behind a valid/ready handshake
module pipelined_alu_muldiv
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_zero,
  output logic             o_overflow,
  output logic             o_div_by_zero
);
  localparam int SHW = $clog2(WIDTH);

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_zero, r_overflow, r_div_by_zero;

  logic             w_accept, w_is_mul, w_is_div, w_start, w_sub, w_carry, w_ovf, w_slt, w_done;
  logic [WIDTH-1:0] w_bx, w_sum, w_alu, w_it_lo, w_it_hi;
  logic [SHW-1:0]   w_shamt;

  assign w_accept = i_in_valid && (r_state == ST_IDLE);
  assign w_is_mul = is_mul_op(i_op);
  assign w_is_div = is_div_op(i_op);
  // Divide by zero skips the iterator and completes like a single-cycle op.
  assign w_start  = w_accept && (w_is_mul || (w_is_div && (i_b != '0)));

  assign w_sub = (i_op == OP_SUB) || (i_op == OP_SLT) || (i_op == OP_SLTU);
  assign w_bx  = w_sub ? ~i_b : i_b;
  assign {w_carry, w_sum} = {1'b0, i_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_sub};
  assign w_ovf = (i_a[WIDTH-1] ~^ w_bx[WIDTH-1]) & (i_a[WIDTH-1] ^ w_sum[WIDTH-1]);
  assign w_slt = w_sum[WIDTH-1] ^ w_ovf;
  assign w_shamt = i_b[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (i_op)
      OP_AND:          w_alu = i_a & i_b;
      OP_OR:           w_alu = i_a | i_b;
      OP_ADD, OP_SUB:  w_alu = w_sum;
      OP_XOR:          w_alu = i_a ^ i_b;
      OP_NOR:          w_alu = ~(i_a | i_b);
      OP_SLTU:         w_alu = {{(WIDTH-1){1'b0}}, ~w_carry};
      OP_SLT:          w_alu = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLL:          w_alu = i_a << w_shamt;
      OP_SRL:          w_alu = i_a >> w_shamt;
      OP_SRA:          w_alu = $unsigned($signed(i_a) >>> w_shamt);
      OP_RSVD, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_alu = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_start     (w_start),
    .i_is_div    (w_is_div),
    .i_is_signed (~i_op[0]),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_done      (w_done),
    .o_lo        (w_it_lo),
    .o_hi        (w_it_hi)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:        if (i_in_valid) w_state_nx = w_is_mul ? ST_MUL : (w_start ? ST_DIV : ST_DONE);
      ST_MUL, ST_DIV: if (w_done) w_state_nx = ST_DONE;
      ST_DONE:        if (i_out_ready) w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == ST_IDLE);
    o_out_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_result      <= '0;
      r_result_hi   <= '0;
      r_zero        <= 1'b0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept && !w_start) begin
      if (w_is_div) begin
        r_result      <= '1;
        r_result_hi   <= i_a;
        r_zero        <= 1'b0;
        r_overflow    <= 1'b0;
        r_div_by_zero <= 1'b1;
      end else begin
        r_result      <= w_alu;
        r_result_hi   <= '0;
        r_zero        <= (w_alu == '0) && (i_op != OP_RSVD);
        r_overflow    <= w_ovf && ((i_op == OP_ADD) || (i_op == OP_SUB));
        r_div_by_zero <= 1'b0;
      end
    end else if (((r_state == ST_MUL) || (r_state == ST_DIV)) && w_done) begin
      r_result      <= w_it_lo;
      r_result_hi   <= w_it_hi;
      r_zero        <= (w_it_lo == '0);
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end
  end

  assign o_result      = r_result;
  assign o_result_hi   = r_result_hi;
  assign o_zero        = r_zero;
  assign o_overflow    = r_overflow;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_pipelined_alu_muldiv.sv
// tb/tb_pipelined_alu_muldiv.sv - scoreboard bench for pipelined_alu_muldiv (WIDTH=32)
module tb_pipelined_alu_muldiv;

  localparam logic [3:0] ADD = 4'h2, SUB = 4'h6, SLT = 4'h7, SLTU = 4'h5, SRA = 4'hA;
  localparam logic [3:0] MULT = 4'hC, MULTU = 4'hD, DIV = 4'hE, DIVU = 4'hF;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        dbz;
    int          lat;
  } exp_t;

  logic        clk, reset_n, in_valid, out_ready;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        in_ready, out_valid, zero, overflow, div_by_zero;
  logic [31:0] result, result_hi;

  exp_t scoreboard[$];
  int   errors = 0;
  int   checks = 0;

  pipelined_alu_muldiv #(.WIDTH(32)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_op(op), .i_a(a), .i_b(b), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_result(result), .o_result_hi(result_hi), .o_zero(zero), .o_overflow(overflow),
    .o_div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op_i, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx, sy, s;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0; e.hi = '0; e.ovf = 1'b0; e.dbz = 1'b0; e.lat = 1;
    case (op_i)
      4'h0: e.res = x & y;
      4'h1: e.res = x | y;
      4'h2: begin e.res = x + y; s = sx + sy; e.ovf = (s != longint'($signed(e.res))); end
      4'h3: e.res = x ^ y;
      4'h4: e.res = ~(x | y);
      4'h5: e.res = {31'b0, x < y};
      4'h6: begin e.res = x - y; s = sx - sy; e.ovf = (s != longint'($signed(e.res))); end
      4'h7: e.res = {31'b0, $signed(x) < $signed(y)};
      4'h8: e.res = x << y[4:0];
      4'h9: e.res = x >> y[4:0];
      4'hA: e.res = 32'($signed(x) >>> y[4:0]);
      4'hC: begin p = 64'(sx * sy); {e.hi, e.res} = p; e.lat = 32; end
      4'hD: begin p = {32'b0, x} * {32'b0, y}; {e.hi, e.res} = p; e.lat = 32; end
      4'hE, 4'hF: begin
        if (y == 0) begin
          e.res = '1; e.hi = x; e.dbz = 1'b1;
        end else if (op_i == 4'hE) begin
          e.res = 32'(sx / sy); e.hi = 32'(sx % sy); e.lat = 32;
        end else begin
          e.res = x / y; e.hi = x % y; e.lat = 32;
        end
      end
      default: ;
    endcase
    e.zero = (e.res == 0) && (op_i != 4'hB);
    return e;
  endfunction

  // Scoreboard consumer: compares each handed-off result against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (scoreboard.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got result=%h hi=%h with empty scoreboard", result, result_hi);
      end else begin
        exp_t e;
        e = scoreboard.pop_front();
        if (result !== e.res || result_hi !== e.hi || zero !== e.zero ||
            overflow !== e.ovf || div_by_zero !== e.dbz) begin
          errors++;
          $display("FAIL sb_compare got res=%h hi=%h z=%b ov=%b dz=%b want res=%h hi=%h z=%b ov=%b dz=%b",
                   result, result_hi, zero, overflow, div_by_zero, e.res, e.hi, e.zero, e.ovf, e.dbz);
        end
      end
    end
  end

  // Called at posedge+2; returns the number of edges from accept until out_valid is seen.
  task automatic issue(input logic [3:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       output int lat);
    scoreboard.push_back(model(op_i, a_i, b_i));
    op = op_i; a = a_i; b = b_i; in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #2;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #2;
    checks += 7;
    if (in_ready !== 1'b1)      begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0)     begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (result !== 32'h0)       begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    if (result_hi !== 32'h0)    begin errors++; $display("FAIL reset_result_hi got=%h want=0", result_hi); end
    if (zero !== 1'b0)          begin errors++; $display("FAIL reset_zero got=%b want=0", zero); end
    if (overflow !== 1'b0)      begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    if (div_by_zero !== 1'b0)   begin errors++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    issue(ADD, 32'h7FFF_FFFF, 32'h1, lat);
    checks += 4;
    if (lat !== 1)                  begin errors++; $display("FAIL add_latency got=%0d want=1", lat); end
    if (result !== 32'h8000_0000)   begin errors++; $display("FAIL add_result got=%h want=80000000", result); end
    if (overflow !== 1'b1)          begin errors++; $display("FAIL add_overflow got=%b want=1", overflow); end
    if (zero !== 1'b0)              begin errors++; $display("FAIL add_zero got=%b want=0", zero); end
    retire();
    for (int i = 0; i < 3; i++) begin
      issue(ADD, $urandom, $urandom, lat);
      retire();
    end
  endtask

  task automatic test_compare();
    int lat;
    issue(SLT, 32'hFFFF_FFFF, 32'h1, lat);
    checks++;
    if (result !== 32'h1) begin errors++; $display("FAIL slt_result got=%h want=1", result); end
    retire();
    issue(SLTU, 32'hFFFF_FFFF, 32'h1, lat);
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL sltu_result got=%h want=0", result); end
    retire();
    issue(SUB, 32'h5, 32'h5, lat);
    checks += 2;
    if (result !== 32'h0) begin errors++; $display("FAIL sub_result got=%h want=0", result); end
    if (zero !== 1'b1)    begin errors++; $display("FAIL sub_zero got=%b want=1", zero); end
    retire();
    issue(SLT, 32'h8000_0000, 32'h7FFF_FFFF, lat);
    retire();
    issue(SUB, 32'h8000_0000, 32'h1, lat);
    retire();
  endtask

  task automatic test_logic_shift();
    logic [3:0] ops[8];
    int lat;
    ops = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hB};
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], $urandom, $urandom, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL logic_latency op=%h got=%0d want=1", ops[i], lat); end
      retire();
    end
    issue(SRA, 32'h8000_0000, 32'h21, lat);
    checks++;
    if (result !== 32'hC000_0000) begin errors++; $display("FAIL sra_result got=%h want=c0000000", result); end
    retire();
  endtask

  task automatic test_mul();
    int lat;
    issue(MULT, 32'hFFFF_FFFE, 32'h3, lat);
    checks += 3;
    if (lat !== 32)                begin errors++; $display("FAIL mult_latency got=%0d want=32", lat); end
    if (result_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h want=ffffffff", result_hi); end
    if (result !== 32'hFFFF_FFFA)  begin errors++; $display("FAIL mult_lo got=%h want=fffffffa", result); end
    retire();
    issue(MULTU, 32'hFFFF_FFFE, 32'h3, lat);
    checks += 2;
    if (result_hi !== 32'h2)       begin errors++; $display("FAIL multu_hi got=%h want=2", result_hi); end
    if (result !== 32'hFFFF_FFFA)  begin errors++; $display("FAIL multu_lo got=%h want=fffffffa", result); end
    retire();
    for (int i = 0; i < 4; i++) begin
      issue((i % 2 == 0) ? MULT : MULTU, $urandom, $urandom, lat);
      checks++;
      if (lat !== 32) begin errors++; $display("FAIL mul_rand_latency got=%0d want=32", lat); end
      retire();
    end
  endtask

  task automatic test_div();
    int lat;
    issue(DIV, 32'hFFFF_FFF9, 32'h2, lat);
    checks += 3;
    if (lat !== 32)                  begin errors++; $display("FAIL div_latency got=%0d want=32", lat); end
    if (result !== 32'hFFFF_FFFD)    begin errors++; $display("FAIL div_quot got=%h want=fffffffd", result); end
    if (result_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_rem got=%h want=ffffffff", result_hi); end
    retire();
    issue(DIVU, 32'h9, 32'h0, lat);
    checks += 4;
    if (lat !== 1)                   begin errors++; $display("FAIL dbz_latency got=%0d want=1", lat); end
    if (result !== 32'hFFFF_FFFF)    begin errors++; $display("FAIL dbz_result got=%h want=ffffffff", result); end
    if (result_hi !== 32'h9)         begin errors++; $display("FAIL dbz_hi got=%h want=9", result_hi); end
    if (div_by_zero !== 1'b1)        begin errors++; $display("FAIL dbz_flag got=%b want=1", div_by_zero); end
    retire();
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks += 3;
    if (result !== 32'h8000_0000)    begin errors++; $display("FAIL div_minneg1 got=%h want=80000000", result); end
    if (result_hi !== 32'h0)         begin errors++; $display("FAIL div_minneg1_hi got=%h want=0", result_hi); end
    if (div_by_zero !== 1'b0)        begin errors++; $display("FAIL div_minneg1_dbz got=%b want=0", div_by_zero); end
    retire();
    issue(DIV, 32'h1234_5678, 32'h0, lat);
    retire();
    for (int i = 0; i < 4; i++) begin
      issue((i % 2 == 0) ? DIV : DIVU, $urandom, $urandom_range(1, 32'hFFFF) << (i * 4), lat);
      retire();
    end
  endtask

  task automatic test_hold();
    int lat;
    issue(ADD, 32'h1234, 32'h4321, lat);
    for (int i = 0; i < 5; i++) begin
      op = SUB; a = $urandom; b = $urandom; in_valid = (i % 2 == 0);
      @(posedge clk); #2;
      checks += 4;
      if (in_ready !== 1'b0)       begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%b want=0", i, in_ready); end
      if (out_valid !== 1'b1)      begin errors++; $display("FAIL hold_out_valid cyc=%0d got=%b want=1", i, out_valid); end
      if (result !== 32'h5555)     begin errors++; $display("FAIL hold_result cyc=%0d got=%h want=5555", i, result); end
      if (result_hi !== 32'h0)     begin errors++; $display("FAIL hold_hi cyc=%0d got=%h want=0", i, result_hi); end
    end
    in_valid = 1'b0;
    retire();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_ignored got out_valid=%b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    op = MULT; a = 32'hFFFF_FFFE; b = 32'h3; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_busy got in_ready=%b want=0", in_ready); end
    repeat (8) @(posedge clk);
    #2;
    reset_n = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
    repeat (40) begin
      @(posedge clk); #2;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_aborted got %0d valid cycles want=0", seen); end
    issue(ADD, 32'h2, 32'h3, lat);
    checks++;
    if (result !== 32'h5) begin errors++; $display("FAIL mid_next_add got=%h want=5", result); end
    retire();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[6];
    int lat;
    int want;
    ops = '{ADD, MULTU, SUB, DIV, 4'h3, MULT};
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready idx=%0d got=%b want=1", i, in_ready); end
      issue(ops[i], $urandom, $urandom_range(1, 32'hFFFF_FFFF), lat);
      want = scoreboard[scoreboard.size() - 1].lat;
      checks++;
      if (lat !== want) begin errors++; $display("FAIL b2b_latency idx=%0d got=%0d want=%0d", i, lat, want); end
      retire();
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #2;
    test_add();
    test_compare();
    test_logic_shift();
    test_mul();
    test_div();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    checks++;
    if (scoreboard.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want=0", scoreboard.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
